// File: rtl/adaptive_thresh_pkg.sv
// Shared types and constants for the adaptive threshold pipeline.
// Tap offsets walk the 3x3 window in raster order.
package adaptive_thresh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ACC,
        WRITE,
        DONE
    } state_t;

    localparam logic [12:0] RECIP_9  = 13'd7282;
    localparam int          SUM_BITS = 12;
    localparam int          TAPS     = 9;
    localparam logic [3:0]  LAST_TAP = 4'(TAPS - 1);

    function automatic logic signed [1:0] tap_row_off(input logic [3:0] k);
        if (k < 4'd3)
            return -2'sd1;
        else if (k < 4'd6)
            return 2'sd0;
        else
            return 2'sd1;
    endfunction

    function automatic logic signed [1:0] tap_col_off(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: return -2'sd1;
            4'd1, 4'd4, 4'd7: return 2'sd0;
            default:          return 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/clamp_coord.sv
// Adds a -1/0/+1 offset to a coordinate and clamps to [0, 2**BITS-1],
// which gives edge replication for the neighbourhood taps.
module clamp_coord #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0]   base,
    input  logic signed [1:0] offset,
    output logic [BITS-1:0]   coord
);

    logic [BITS+1:0] sum;

    assign sum = {2'b00, base} + {{BITS{offset[1]}}, offset};

    // Top bit flags underflow, next bit flags overflow past the last index
    always_comb begin
        if (sum[BITS+1])
            coord = '0;
        else if (sum[BITS])
            coord = '1;
        else
            coord = sum[BITS-1:0];
    end

endmodule

// File: rtl/local_mean_threshold.sv
// Raster-scans the image and writes floor(mean of 3x3) per pixel,
// 11 cycles per pixel: 9 tap reads, accumulate, write.
module local_mean_threshold
    import adaptive_thresh_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   finished
);

    localparam int POS_BITS = WIDTH_BITS + HEIGHT_BITS;

    state_t                state;
    state_t                state_next;
    logic [POS_BITS-1:0]   pos;
    logic [3:0]            tap;
    logic [SUM_BITS-1:0]   acc;
    logic [SUM_BITS-1:0]   acc_final;
    logic [7:0]            mean;
    logic                  last_pixel;

    assign oThresholdCol = pos[WIDTH_BITS-1:0];
    assign oThresholdRow = pos[POS_BITS-1:WIDTH_BITS];
    assign last_pixel    = &pos;
    assign acc_final     = acc + SUM_BITS'(iImageData);

    // Multiply by 2**16/9 (rounded up) is an exact floor divide for sums up to 2295
    assign mean = 8'(({13'b0, acc_final} * {12'b0, RECIP_9}) >> 16);

    clamp_coord #(
        .BITS   (HEIGHT_BITS)
    ) u_clamp_row (
        .base   (oThresholdRow),
        .offset (tap_row_off(tap)),
        .coord  (oImageRow)
    );

    clamp_coord #(
        .BITS   (WIDTH_BITS)
    ) u_clamp_col (
        .base   (oThresholdCol),
        .offset (tap_col_off(tap)),
        .coord  (oImageCol)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state: start is only honoured when not scanning
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (iStart) state_next = READ;
            READ:    if (tap == LAST_TAP) state_next = ACC;
            ACC:     state_next = WRITE;
            WRITE:   state_next = last_pixel ? DONE : READ;
            DONE:    if (iStart) state_next = READ;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        oThresholdWren = 1'b0;
        finished       = 1'b0;
        unique case (state)
            WRITE:   oThresholdWren = 1'b1;
            DONE:    finished = 1'b1;
            default: ;
        endcase
    end

    // Pixel position, tap counter, running sum and registered mean
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos            <= '0;
            tap            <= '0;
            acc            <= '0;
            oThresholdData <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (iStart) begin
                        pos <= '0;
                        tap <= '0;
                        acc <= '0;
                    end
                end
                READ: begin
                    if (tap != 4'd0)
                        acc <= acc + SUM_BITS'(iImageData);
                    if (tap != LAST_TAP)
                        tap <= tap + 4'd1;
                end
                ACC: begin
                    oThresholdData <= mean;
                end
                WRITE: begin
                    if (!last_pixel)
                        pos <= pos + 1'b1;
                    tap <= '0;
                    acc <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_local_mean_threshold.sv
// Bench for local_mean_threshold on a 16x16 image with a 1-cycle RAM model.
// Expected means come from a direct clamped-window sum divided by 9.
module tb_local_mean_threshold;

    localparam int WB   = 4;
    localparam int HB   = 4;
    localparam int NPIX = 256;
    localparam int LAT  = 11 * NPIX + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          iStart;
    logic [WB-1:0] oImageCol;
    logic [HB-1:0] oImageRow;
    logic [7:0]    iImageData;
    logic [WB-1:0] oThresholdCol;
    logic [HB-1:0] oThresholdRow;
    logic [7:0]    oThresholdData;
    logic          oThresholdWren;
    logic          finished;

    always #5 clock = ~clock;

    local_mean_threshold #(
        .WIDTH_BITS  (WB),
        .HEIGHT_BITS (HB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .iStart         (iStart),
        .oImageCol      (oImageCol),
        .oImageRow      (oImageRow),
        .iImageData     (iImageData),
        .oThresholdCol  (oThresholdCol),
        .oThresholdRow  (oThresholdRow),
        .oThresholdData (oThresholdData),
        .oThresholdWren (oThresholdWren),
        .finished       (finished)
    );

    logic [7:0] img [NPIX];
    logic [7:0] thr [NPIX];

    always @(posedge clock)
        iImageData <= img[{oImageRow, oImageCol}];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] bg;
        int         sr;
        int         sc;
        logic [7:0] sv;
        int         pr;
        int         pc;
        logic [7:0] pexp;
    } vec_t;

    exp_t sbq[$];
    exp_t e;
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   wren_cnt = 0;
    bit   sb_en    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : ((v > 15) ? 15 : v);
    endfunction

    function automatic logic [7:0] ref_mean(input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += int'(img[clampi(r + dr) * 16 + clampi(c + dc)]);
        return 8'(s / 9);
    endfunction

    always @(negedge clock) begin
        if (oThresholdWren) begin
            wren_cnt++;
            thr[{oThresholdRow, oThresholdCol}] = oThresholdData;
            if (sb_en) begin
                if (sbq.size() == 0) begin
                    check("sb_underrun", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("thr_addr", int'({oThresholdRow, oThresholdCol}), int'(e.addr));
                    check("thr_data", int'(oThresholdData), int'(e.data));
                end
            end
        end
    end

    task automatic load_image(input logic [7:0] bg, input int sr, input int sc,
                              input logic [7:0] sv);
        for (int i = 0; i < NPIX; i++) begin
            img[i] = bg;
            thr[i] = 8'h5A;
        end
        if (sr >= 0)
            img[sr * 16 + sc] = sv;
    endtask

    task automatic run_pass(input bit mid_pulse);
        int lat;
        sbq.delete();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                sbq.push_back('{addr: 8'(r * 16 + c), data: ref_mean(r, c)});
        wren_cnt = 0;
        sb_en = 1'b1;
        @(negedge clock) iStart = 1'b1;
        @(negedge clock) iStart = 1'b0;
        check("fin_clear", int'(finished), 0);
        lat = 1;
        while (!finished && lat < LAT + 100) begin
            iStart = (mid_pulse && lat == 500);
            @(negedge clock);
            lat++;
        end
        iStart = 1'b0;
        check("latency", lat, LAT);
        check("wren_cnt", wren_cnt, NPIX);
        check("sb_left", sbq.size(), 0);
        sbq.delete();
        sb_en = 1'b0;
    endtask

    vec_t vt[7];

    initial begin
        int w;
        vt[0] = '{8'd100, -1, 0, 8'd0,   7,  7,  8'd100};
        vt[1] = '{8'd0,    5, 5, 8'd255, 4,  4,  8'd28};
        vt[2] = '{8'd0,    5, 5, 8'd255, 3,  3,  8'd0};
        vt[3] = '{8'd0,    0, 0, 8'd90,  0,  0,  8'd40};
        vt[4] = '{8'd0,    0, 0, 8'd90,  0,  1,  8'd20};
        vt[5] = '{8'd0,    0, 0, 8'd90,  1,  1,  8'd10};
        vt[6] = '{8'd255, -1, 0, 8'd0,   15, 15, 8'd255};

        reset  = 1'b1;
        iStart = 1'b0;
        load_image(8'd0, -1, 0, 8'd0);
        repeat (3) @(negedge clock);
        check("rst_wren", int'(oThresholdWren), 0);
        check("rst_fin", int'(finished), 0);
        check("rst_data", int'(oThresholdData), 0);
        check("rst_addr", int'({oThresholdRow, oThresholdCol}), 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            load_image(vt[i].bg, vt[i].sr, vt[i].sc, vt[i].sv);
            run_pass(1'b0);
            check("probe", int'(thr[vt[i].pr * 16 + vt[i].pc]), int'(vt[i].pexp));
        end

        for (int i = 0; i < NPIX; i++)
            img[i] = 8'($urandom_range(0, 255));
        sbq.delete();
        sb_en = 1'b0;
        @(negedge clock) iStart = 1'b1;
        @(negedge clock) iStart = 1'b0;
        w = 0;
        while ({oThresholdRow, oThresholdCol} != 8'd37 && w < 1000) begin
            @(negedge clock);
            w++;
        end
        check("reach_37", int'({oThresholdRow, oThresholdCol}), 37);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_wren", int'(oThresholdWren), 0);
        check("async_fin", int'(finished), 0);
        check("async_data", int'(oThresholdData), 0);
        check("async_addr", int'({oThresholdRow, oThresholdCol}), 0);
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        run_pass(1'b0);

        for (int i = 0; i < NPIX; i++)
            img[i] = 8'($urandom_range(0, 255));
        run_pass(1'b1);
        check("done_hold", int'(finished), 1);
        img[0] = 8'd7;
        img[255] = 8'd250;
        run_pass(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
